// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: widths, port ids, flit layout and the XY route function.
package noc_pkg;

    localparam int PORT_N  = 5;
    localparam int PORT_W  = 3;
    localparam int FLIT_W  = 16;
    localparam int COORD_W = 4;
    localparam int PLD_W   = FLIT_W - 2 - 2 * COORD_W;

    localparam logic [PORT_W-1:0] LOCAL = 3'd0;
    localparam logic [PORT_W-1:0] NORTH = 3'd1;
    localparam logic [PORT_W-1:0] EAST  = 3'd2;
    localparam logic [PORT_W-1:0] SOUTH = 3'd3;
    localparam logic [PORT_W-1:0] WEST  = 3'd4;

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef struct packed {
        logic [1:0]         ftype;
        logic [PLD_W-1:0]   payload;
        logic [COORD_W-1:0] dy;
        logic [COORD_W-1:0] dx;
    } flit_t;

    // Bit 0 of the type marks a packet start, bit 1 a packet end.
    function automatic logic is_head(input logic [1:0] ftype);
        return ftype[0];
    endfunction

    function automatic logic is_tail(input logic [1:0] ftype);
        return ftype[1];
    endfunction

    function automatic logic [PORT_W-1:0] xy_route(
        input logic [COORD_W-1:0] dx,
        input logic [COORD_W-1:0] dy,
        input logic [COORD_W-1:0] my_x,
        input logic [COORD_W-1:0] my_y
    );
        logic [PORT_W-1:0] port;
        port = LOCAL;
        if (dx > my_x)      port = EAST;
        else if (dx < my_x) port = WEST;
        else if (dy > my_y) port = NORTH;
        else if (dy < my_y) port = SOUTH;
        return port;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Power-of-two flit FIFO with a registered front; push into a full FIFO is ignored.
module flit_fifo #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [FLIT_W-1:0] din_i,
    input  logic              pop_i,
    output logic [FLIT_W-1:0] front_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count == FULL_CNT);
    assign empty_o = (count == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign front_o = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; reset clears the pointers, not the contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/inport_ctrl.sv
// Mesh router input port: buffers flits, routes head flits XY, and forwards granted packets wormhole-style.
module inport_ctrl
    import noc_pkg::*;
#(
    parameter int                 PORTID = 0,
    parameter int                 DEPTH  = 4,
    parameter logic [COORD_W-1:0] MY_X   = '0,
    parameter logic [COORD_W-1:0] MY_Y   = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [PORT_W-1:0] port_o,
    output logic              req_o,
    input  logic              grt_i,
    output logic [FLIT_W-1:0] flit_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              drop_o
);

    if (PORTID < 0 || PORTID >= PORT_N || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("inport_ctrl: illegal PORTID or DEPTH");
    end

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]        state_q;
    logic [PORT_W-1:0] port_q;
    logic [FLIT_W-1:0] front;
    flit_t             front_f;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign push    = valid_i & ~full;
    assign ready_o = ~full;
    assign front_f = front;
    assign flit_o  = front_f;
    assign req_o   = (state_q == ACTIVE);
    assign port_o  = port_q;

    flit_fifo #(
        .DEPTH  (DEPTH),
        .FLIT_W (FLIT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .din_i   (flit_i),
        .pop_i   (pop),
        .front_o (front),
        .full_o  (full),
        .empty_o (empty)
    );

    // Stray body/tail flits at the front while idle are discarded one per cycle.
    always_comb begin
        pop     = 1'b0;
        drop_o  = 1'b0;
        valid_o = 1'b0;
        if (state_q == ACTIVE) begin
            valid_o = grt_i & ~empty;
            pop     = valid_o & ready_i;
        end else if (!empty && !is_head(front_f.ftype)) begin
            pop    = 1'b1;
            drop_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            port_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty && is_head(front_f.ftype)) begin
                        port_q  <= xy_route(front_f.dx, front_f.dy, MY_X, MY_Y);
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pop && is_tail(front_f.ftype)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inport_ctrl.sv
// Directed table-driven bench for inport_ctrl (MY_X=1, MY_Y=1, DEPTH=4).
module tb_inport_ctrl;

    logic        clk_i;
    logic        rst_ni;
    logic [15:0] flit_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  port_o;
    logic        req_o;
    logic        grt_i;
    logic [15:0] flit_o;
    logic        valid_o;
    logic        ready_i;
    logic        drop_o;

    int n_chk;
    int n_fail;

    inport_ctrl #(
        .PORTID (0),
        .DEPTH  (4),
        .MY_X   (4'd1),
        .MY_Y   (4'd1)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flit_i  (flit_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .port_o  (port_o),
        .req_o   (req_o),
        .grt_i   (grt_i),
        .flit_o  (flit_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .drop_o  (drop_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic        rst_n;
        logic [15:0] flit;
        logic        vld;
        logic        grt;
        logic        rdy;
        logic        e_rdy;
        logic        e_req;
        logic [2:0]  e_port;   // 7 = not checked
        logic        e_vld;
        logic [15:0] e_flit;   // checked only when e_vld
        logic        e_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string tag, input logic rst_n, input logic [15:0] f,
                       input logic v, input logic g, input logic r,
                       input logic erdy, input logic ereq, input logic [2:0] eport,
                       input logic evld, input logic [15:0] eflit, input logic edrop);
        vec_t e;
        e.tag = tag; e.rst_n = rst_n; e.flit = f; e.vld = v; e.grt = g; e.rdy = r;
        e.e_rdy = erdy; e.e_req = ereq; e.e_port = eport; e.e_vld = evld;
        e.e_flit = eflit; e.e_drop = edrop;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        string t;
        int    k;
        n_chk = 0; n_fail = 0;
        rst_ni = 1'b0; flit_i = '0; valid_i = 1'b0; grt_i = 1'b0; ready_i = 1'b0;
        repeat (2) @(posedge clk_i);

        add("reset",  1, 16'h0000, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 0);
        // SINGLE to (3,1) -> EAST
        add("single", 1, 16'hC013, 1, 1, 1,  1, 0, 0, 0, 16'h0000, 0);
        add("single", 1, 16'h0000, 0, 1, 1,  1, 0, 0, 0, 16'h0000, 0);
        add("single", 1, 16'h0000, 0, 1, 1,  1, 1, 2, 1, 16'hC013, 0);
        add("single", 1, 16'h0000, 0, 1, 1,  1, 0, 7, 0, 16'h0000, 0);
        // 4-flit packet to (1,0) -> SOUTH, grant withheld for 5 cycles
        add("pkt4",   1, 16'h4001, 1, 0, 1,  1, 0, 7, 0, 16'h0000, 0);
        add("pkt4",   1, 16'h0A01, 1, 0, 1,  1, 0, 7, 0, 16'h0000, 0);
        add("pkt4",   1, 16'h0A02, 1, 0, 1,  1, 1, 3, 0, 16'h0000, 0);
        add("pkt4",   1, 16'h8A03, 1, 0, 1,  1, 1, 3, 0, 16'h0000, 0);
        add("pkt4",   1, 16'h0000, 0, 0, 1,  0, 1, 3, 0, 16'h0000, 0);
        add("pkt4",   1, 16'h0000, 0, 1, 1,  0, 1, 3, 1, 16'h4001, 0);
        add("pkt4",   1, 16'h0000, 0, 1, 1,  1, 1, 3, 1, 16'h0A01, 0);
        add("pkt4",   1, 16'h0000, 0, 1, 1,  1, 1, 3, 1, 16'h0A02, 0);
        add("pkt4",   1, 16'h0000, 0, 1, 1,  1, 1, 3, 1, 16'h8A03, 0);
        add("pkt4",   1, 16'h0000, 0, 1, 1,  1, 0, 7, 0, 16'h0000, 0);
        // fill to DEPTH, fifth flit (0B04) must be refused
        add("full",   1, 16'h4011, 1, 0, 1,  1, 0, 7, 0, 16'h0000, 0);
        add("full",   1, 16'h0B01, 1, 0, 1,  1, 0, 7, 0, 16'h0000, 0);
        add("full",   1, 16'h0B02, 1, 0, 1,  1, 1, 0, 0, 16'h0000, 0);
        add("full",   1, 16'h0B03, 1, 0, 1,  1, 1, 0, 0, 16'h0000, 0);
        add("full",   1, 16'h0B04, 1, 0, 1,  0, 1, 0, 0, 16'h0000, 0);
        add("full",   1, 16'h0000, 0, 1, 1,  0, 1, 0, 1, 16'h4011, 0);
        add("full",   1, 16'h0000, 0, 0, 1,  1, 1, 0, 0, 16'h0000, 0);
        add("full",   1, 16'h0000, 0, 1, 1,  1, 1, 0, 1, 16'h0B01, 0);
        add("full",   1, 16'h0000, 0, 1, 1,  1, 1, 0, 1, 16'h0B02, 0);
        add("full",   1, 16'h0000, 0, 1, 1,  1, 1, 0, 1, 16'h0B03, 0);
        add("full",   1, 16'h8B05, 1, 1, 1,  1, 1, 0, 0, 16'h0000, 0);
        add("full",   1, 16'h0000, 0, 1, 1,  1, 1, 0, 1, 16'h8B05, 0);
        add("full",   1, 16'h0000, 0, 1, 1,  1, 0, 7, 0, 16'h0000, 0);
        // stray BODY then TAIL while idle
        add("drop",   1, 16'h0005, 1, 0, 0,  1, 0, 7, 0, 16'h0000, 0);
        add("drop",   1, 16'h8006, 1, 0, 0,  1, 0, 7, 0, 16'h0000, 1);
        add("drop",   1, 16'h0000, 0, 0, 0,  1, 0, 7, 0, 16'h0000, 1);
        add("drop",   1, 16'h0000, 0, 0, 0,  1, 0, 7, 0, 16'h0000, 0);
        add("drop",   1, 16'h0000, 0, 0, 0,  1, 0, 7, 0, 16'h0000, 0);
        // HEAD to (1,1) -> LOCAL, FIFO empties mid-packet, then ready_i stalls
        add("stall",  1, 16'h4011, 1, 1, 1,  1, 0, 7, 0, 16'h0000, 0);
        add("stall",  1, 16'h0000, 0, 1, 1,  1, 0, 7, 0, 16'h0000, 0);
        add("stall",  1, 16'h0000, 0, 1, 1,  1, 1, 0, 1, 16'h4011, 0);
        add("stall",  1, 16'h0C01, 1, 1, 0,  1, 1, 0, 0, 16'h0000, 0);
        add("stall",  1, 16'h8C02, 1, 1, 0,  1, 1, 0, 1, 16'h0C01, 0);
        add("stall",  1, 16'h0000, 0, 1, 0,  1, 1, 0, 1, 16'h0C01, 0);
        add("stall",  1, 16'h0000, 0, 1, 1,  1, 1, 0, 1, 16'h0C01, 0);
        add("stall",  1, 16'h0000, 0, 1, 1,  1, 1, 0, 1, 16'h8C02, 0);
        add("stall",  1, 16'h0000, 0, 1, 1,  1, 0, 7, 0, 16'h0000, 0);
        // reset mid-packet, leftovers become strays
        add("midrst", 1, 16'h4001, 1, 0, 1,  1, 0, 7, 0, 16'h0000, 0);
        add("midrst", 1, 16'h0000, 0, 0, 1,  1, 0, 7, 0, 16'h0000, 0);
        add("midrst", 1, 16'h0000, 0, 0, 1,  1, 1, 3, 0, 16'h0000, 0);
        add("midrst", 0, 16'h0000, 0, 0, 1,  1, 1, 3, 0, 16'h0000, 0);
        add("midrst", 1, 16'h0D01, 1, 0, 1,  1, 0, 0, 0, 16'h0000, 0);
        add("midrst", 1, 16'h8D02, 1, 0, 1,  1, 0, 0, 0, 16'h0000, 1);
        add("midrst", 1, 16'h0000, 0, 0, 1,  1, 0, 0, 0, 16'h0000, 1);
        add("midrst", 1, 16'h0000, 0, 0, 1,  1, 0, 0, 0, 16'h0000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk_i);
            rst_ni  = tbl[i].rst_n;
            flit_i  = tbl[i].flit;
            valid_i = tbl[i].vld;
            grt_i   = tbl[i].grt;
            ready_i = tbl[i].rdy;
            #1;
            t = $sformatf("%s[%0d]", tbl[i].tag, i);
            chk({t, ".ready_o"}, 32'(ready_o), 32'(tbl[i].e_rdy));
            chk({t, ".req_o"},   32'(req_o),   32'(tbl[i].e_req));
            if (tbl[i].e_port != 3'd7)
                chk({t, ".port_o"}, 32'(port_o), 32'(tbl[i].e_port));
            chk({t, ".valid_o"}, 32'(valid_o), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld)
                chk({t, ".flit_o"}, 32'(flit_o), 32'(tbl[i].e_flit));
            chk({t, ".drop_o"},  32'(drop_o),  32'(tbl[i].e_drop));
        end

        // Back-to-back singles: (0,1) -> WEST, then (1,2) -> NORTH; bounded wait on req_o.
        @(negedge clk_i);
        rst_ni = 1'b1; flit_i = 16'hC010; valid_i = 1'b1; grt_i = 1'b1; ready_i = 1'b1;
        @(negedge clk_i);
        flit_i = 16'hC021;
        #1;
        k = 0;
        while (!req_o && k < 10) begin
            @(negedge clk_i);
            valid_i = 1'b0;
            #1;
            k++;
        end
        chk("west.req_latency", 32'(k), 32'd1);
        chk("west.port_o",  32'(port_o),  32'd4);
        chk("west.valid_o", 32'(valid_o), 32'd1);
        chk("west.flit_o",  32'(flit_o),  32'hC010);
        @(negedge clk_i);
        #1;
        chk("north.req_gap", 32'(req_o), 32'd0);
        k = 0;
        while (!req_o && k < 10) begin
            @(negedge clk_i);
            #1;
            k++;
        end
        chk("north.req_wait", 32'(k < 10), 32'd1);
        chk("north.port_o",  32'(port_o),  32'd1);
        chk("north.flit_o",  32'(flit_o),  32'hC021);
        @(negedge clk_i);
        #1;
        chk("north.req_end", 32'(req_o), 32'd0);
        chk("north.ready_o", 32'(ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
